cmd_scheduler: RTL and testbench

Sequences player commands into the single 8-bit `inputs` command bus of the stats block. Arbitrates between two requesters: the UART receive byte stream and six debounced push buttons. Each granted command is driven for a fixed hold window, then the bus returns to 0x00 for a fixed gap, so stats sees exactly one command edge and re-arms between commands. Unknown codes and commands that are useless while the pet sleeps are filtered out and counted.

---
 rtl/tama_pkg.sv | 49 ++++
 rtl/cmd_fifo.sv | 50 +++++
 rtl/cmd_scheduler.sv | 166 ++++++++++++++++
 tb/tb_cmd_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tama_pkg.sv
// Shared command codes, button indices and scheduler state encoding for the
// pet command path.
package tama_pkg;

  localparam logic [7:0] CMD_NONE  = 8'h00;
  localparam logic [7:0] CMD_EAT   = 8'h65;
  localparam logic [7:0] CMD_PLAY  = 8'h70;
  localparam logic [7:0] CMD_DOC   = 8'h64;
  localparam logic [7:0] CMD_BATH  = 8'h62;
  localparam logic [7:0] CMD_SLEEP = 8'h73;
  localparam logic [7:0] CMD_WAKE  = 8'h77;

  localparam int NUM_BTN = 6;

  localparam logic [2:0] BTN_EAT   = 3'd0;
  localparam logic [2:0] BTN_PLAY  = 3'd1;
  localparam logic [2:0] BTN_DOC   = 3'd2;
  localparam logic [2:0] BTN_BATH  = 3'd3;
  localparam logic [2:0] BTN_SLEEP = 3'd4;
  localparam logic [2:0] BTN_WAKE  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } sched_state_t;

  typedef enum logic {
    SRC_UART = 1'b0,
    SRC_BTN  = 1'b1
  } src_t;

  function automatic logic is_valid_cmd(input logic [7:0] code);
    return code inside {CMD_EAT, CMD_PLAY, CMD_DOC, CMD_BATH, CMD_SLEEP, CMD_WAKE};
  endfunction

  function automatic logic [7:0] btn_cmd(input logic [2:0] idx);
    case (idx)
      BTN_EAT:   return CMD_EAT;
      BTN_PLAY:  return CMD_PLAY;
      BTN_DOC:   return CMD_DOC;
      BTN_BATH:  return CMD_BATH;
      BTN_SLEEP: return CMD_SLEEP;
      BTN_WAKE:  return CMD_WAKE;
      default:   return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO holding received UART command bytes; the head entry
// is visible on rd_data whenever empty is low.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are valid, so clearing the array would add nothing.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Arbitrates UART and button commands onto the stats command bus, holding each
// command for a fixed window followed by a fixed idle gap.
module cmd_scheduler
  import tama_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         uart_data,
  input  logic               uart_valid,
  input  logic [NUM_BTN-1:0] btn,
  input  logic               is_sleeping,
  output logic [7:0]         cmd_out,
  output logic               busy,
  output logic               fifo_full,
  output logic [7:0]         drop_count
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  logic [7:0]         uart_data_q;
  logic               uart_valid_q;
  logic [NUM_BTN-1:0] btn_q;
  logic [NUM_BTN-1:0] btn_prev;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] btn_clr;
  logic [2:0]         btn_sel;
  src_t               prio;

  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       fifo_wr;
  logic       uart_ok;
  logic       uart_drop;

  logic       uart_req;
  logic       btn_req;
  logic       grant;
  logic       grant_uart;
  logic       filtered;
  logic [7:0] grant_code;
  logic [8:0] drop_sum;

  sched_state_t  state;
  sched_state_t  state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [7:0]    cmd_next;

  // Inputs are registered once; this stage sets the two-edge request-to-bus latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uart_data_q  <= '0;
      uart_valid_q <= 1'b0;
      btn_q        <= '0;
      btn_prev     <= '0;
    end else begin
      uart_data_q  <= uart_data;
      uart_valid_q <= uart_valid;
      btn_q        <= btn;
      btn_prev     <= btn_q;
    end
  end

  assign uart_ok   = is_valid_cmd(uart_data_q);
  assign fifo_wr   = uart_valid_q && uart_ok && !fifo_full;
  assign uart_drop = uart_valid_q && (!uart_ok || fifo_full);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (uart_data_q),
    .rd_en   (grant_uart),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    btn_sel = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) btn_sel = 3'(i);
    end
  end

  assign uart_req   = !fifo_empty;
  assign btn_req    = |pending;
  assign grant      = (state == ST_IDLE) && (uart_req || btn_req);
  assign grant_uart = (state == ST_IDLE) && uart_req && (!btn_req || prio == SRC_UART);
  assign grant_code = grant_uart ? fifo_head : btn_cmd(btn_sel);
  assign filtered   = grant && is_sleeping && (grant_code != CMD_WAKE);
  assign btn_clr    = (grant && !grant_uart) ? (NUM_BTN'(1) << btn_sel) : '0;
  assign drop_sum   = {1'b0, drop_count} + 9'(uart_drop) + 9'(filtered);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      prio       <= SRC_UART;
      drop_count <= '0;
    end else begin
      // An edge on a bit being granted this cycle merges into that grant.
      pending    <= (pending | (btn_q & ~btn_prev)) & ~btn_clr;
      if (grant) prio <= grant_uart ? SRC_BTN : SRC_UART;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    cnt_next   = cnt;
    cmd_next   = cmd_out;
    unique case (state)
      ST_IDLE: begin
        if (grant && !filtered) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LOAD;
          cmd_next   = grant_code;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_next = ST_GAP;
          cnt_next   = GAP_LOAD;
          cmd_next   = CMD_NONE;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt == '0) state_next = ST_IDLE;
        else           cnt_next   = cnt - CW'(1);
      end
      default: begin
        state_next = ST_IDLE;
        cmd_next   = CMD_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cmd_out <= CMD_NONE;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      cmd_out <= cmd_next;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_cmd_scheduler.sv
// Bench for cmd_scheduler: directed scenarios against hand-derived traces and a
// randomized run against a transaction-level reference model.
module tb_cmd_scheduler;

  localparam int HOLD  = 4;
  localparam int GAP   = 4;
  localparam int DEPTH = 4;
  localparam int NS    = 512;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] uart_data = 8'h00;
  logic       uart_valid = 1'b0;
  logic [5:0] btn = 6'b0;
  logic       is_sleeping = 1'b0;
  logic [7:0] cmd_out;
  logic       busy;
  logic       fifo_full;
  logic [7:0] drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] codes [6] = '{8'h65, 8'h70, 8'h64, 8'h62, 8'h73, 8'h77};

  cmd_scheduler #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .uart_data   (uart_data),
    .uart_valid  (uart_valid),
    .btn         (btn),
    .is_sleeping (is_sleeping),
    .cmd_out     (cmd_out),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: a command queue, pending flags, and time since the last
  // bus grant; the bus is driven while age < HOLD and busy while age < HOLD+GAP.
  logic [7:0] m_q [$];
  logic [5:0] m_pend, m_btn1, m_btn2;
  logic       m_uv1;
  logic [7:0] m_ud1;
  logic       m_ptr_btn;
  logic [7:0] m_code;
  int         m_age;
  int         m_drop;

  function automatic bit is_code(input logic [7:0] b);
    for (int i = 0; i < 6; i++) if (codes[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pend = '0; m_btn1 = '0; m_btn2 = '0;
    m_uv1 = 1'b0; m_ud1 = '0; m_ptr_btn = 1'b0;
    m_code = '0; m_age = 1000; m_drop = 0;
  endtask

  task automatic model_edge();
    int         drops = 0;
    int         qsize = m_q.size();
    logic [5:0] rise = m_btn1 & ~m_btn2;
    logic [5:0] clr = '0;
    logic [7:0] code = 8'h00;
    bit         have = 1'b0;
    bit         from_uart = 1'b0;
    if (m_age >= HOLD + GAP) begin
      if (qsize > 0 && (m_pend == 0 || !m_ptr_btn)) begin
        code = m_q.pop_front(); from_uart = 1'b1; have = 1'b1;
      end else if (m_pend != 0) begin
        for (int i = 5; i >= 0; i--) if (m_pend[i]) begin code = codes[i]; clr = 6'b1 << i; end
        have = 1'b1;
      end
    end
    if (have) begin
      m_ptr_btn = from_uart;
      if (is_sleeping && code != 8'h77) drops++;
      else begin m_code = code; m_age = -1; end
    end
    if (m_uv1) begin
      if (!is_code(m_ud1) || qsize >= DEPTH) drops++;
      else m_q.push_back(m_ud1);
    end
    m_pend = (m_pend | rise) & ~clr;
    m_btn2 = m_btn1; m_btn1 = btn;
    m_uv1 = uart_valid; m_ud1 = uart_data;
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    if (m_age < 1000) m_age++;
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    else model_reset();
    #1;
  endtask

  logic       s_uv  [NS];
  logic [7:0] s_ud  [NS];
  logic [5:0] s_btn [NS];
  logic [7:0] tr_cmd  [NS];
  logic       tr_busy [NS];
  logic       tr_full [NS];

  task automatic clear_script();
    for (int i = 0; i < NS; i++) begin s_uv[i] = 1'b0; s_ud[i] = 8'h00; s_btn[i] = 6'b0; end
  endtask

  // Sample i is taken just after the edge that captured stimulus i.
  task automatic run_script(input int n);
    for (int i = 0; i < n; i++) begin
      uart_valid = s_uv[i]; uart_data = s_ud[i]; btn = s_btn[i];
      step();
      tr_cmd[i] = cmd_out; tr_busy[i] = busy; tr_full[i] = fifo_full;
    end
    uart_valid = 1'b0;
  endtask

  task automatic apply_reset();
    uart_valid = 1'b0; uart_data = 8'h00; btn = 6'b0; is_sleeping = 1'b0;
    reset_n = 1'b0;
    model_reset();
    step(); step();
    reset_n = 1'b1;
    clear_script();
  endtask

  function automatic logic [7:0] window(input int i, input int start, input logic [7:0] code);
    return (i >= start && i < start + HOLD) ? code : 8'h00;
  endfunction

  task automatic test_reset();
    #1;
    n_cmp++; if (cmd_out !== 8'h00) begin n_bad++; $display("FAIL reset_cmd got %h want 00", cmd_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b want 0", fifo_full); end
    n_cmp++; if (drop_count !== 8'h00) begin n_bad++; $display("FAIL reset_drop got %h want 00", drop_count); end
    apply_reset();
  endtask

  task automatic test_uart_single();
    logic [7:0] want;
    apply_reset();
    s_uv[0] = 1'b1; s_ud[0] = 8'h65;
    run_script(12);
    for (int i = 0; i < 12; i++) begin
      want = window(i, 2, 8'h65);
      n_cmp++; if (tr_cmd[i] !== want) begin n_bad++; $display("FAIL single_cmd[%0d] got %h want %h", i, tr_cmd[i], want); end
      n_cmp++; if (tr_busy[i] !== (i >= 2 && i < 2 + HOLD + GAP)) begin
        n_bad++; $display("FAIL single_busy[%0d] got %b", i, tr_busy[i]);
      end
    end
    n_cmp++; if (drop_count !== 8'h00) begin n_bad++; $display("FAIL single_drop got %h want 00", drop_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    apply_reset();
    s_uv[0] = 1'b1; s_ud[0] = 8'h70;
    s_uv[1] = 1'b1; s_ud[1] = 8'h41;
    s_uv[2] = 1'b1; s_ud[2] = 8'h64;
    run_script(20);
    for (int i = 0; i < 20; i++) begin
      want = window(i, 2, 8'h70) | window(i, 11, 8'h64);
      n_cmp++; if (tr_cmd[i] !== want) begin n_bad++; $display("FAIL b2b_cmd[%0d] got %h want %h", i, tr_cmd[i], want); end
    end
    n_cmp++; if (drop_count !== 8'h01) begin n_bad++; $display("FAIL b2b_drop got %h want 01", drop_count); end
  endtask

  task automatic test_arbitration();
    logic [7:0] want;
    apply_reset();
    s_uv[0] = 1'b1; s_ud[0] = 8'h62;
    for (int i = 0; i < 26; i++) s_btn[i] = 6'b001001;
    run_script(26);
    for (int i = 0; i < 26; i++) begin
      want = window(i, 2, 8'h62) | window(i, 11, 8'h65) | window(i, 20, 8'h62);
      n_cmp++; if (tr_cmd[i] !== want) begin n_bad++; $display("FAIL arb_cmd[%0d] got %h want %h", i, tr_cmd[i], want); end
    end
    apply_reset();
    for (int i = 0; i < 26; i++) s_btn[i] = (i < 3) ? 6'b000001 : 6'b001001;
    s_uv[4] = 1'b1; s_ud[4] = 8'h64;
    run_script(26);
    for (int i = 0; i < 26; i++) begin
      want = window(i, 2, 8'h65) | window(i, 11, 8'h64) | window(i, 20, 8'h62);
      n_cmp++; if (tr_cmd[i] !== want) begin n_bad++; $display("FAIL alt_cmd[%0d] got %h want %h", i, tr_cmd[i], want); end
    end
  endtask

  task automatic test_sleep_filter();
    logic [7:0] want;
    apply_reset();
    is_sleeping = 1'b1;
    s_uv[0] = 1'b1; s_ud[0] = 8'h70;
    s_uv[1] = 1'b1; s_ud[1] = 8'h77;
    run_script(12);
    for (int i = 0; i < 12; i++) begin
      want = window(i, 3, 8'h77);
      n_cmp++; if (tr_cmd[i] !== want) begin n_bad++; $display("FAIL sleep_cmd[%0d] got %h want %h", i, tr_cmd[i], want); end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (tr_busy[i] !== 1'b0) begin n_bad++; $display("FAIL sleep_busy[%0d] got %b want 0", i, tr_busy[i]); end
    end
    n_cmp++; if (drop_count !== 8'h01) begin n_bad++; $display("FAIL sleep_drop got %h want 01", drop_count); end
    is_sleeping = 1'b0;
  endtask

  task automatic test_fifo_full();
    logic [7:0] want;
    logic [7:0] bytes [6] = '{8'h65, 8'h70, 8'h64, 8'h62, 8'h77, 8'h73};
    apply_reset();
    s_uv[0] = 1'b1; s_ud[0] = 8'h73;
    for (int k = 0; k < 6; k++) begin s_uv[1 + k] = 1'b1; s_ud[1 + k] = bytes[k]; end
    run_script(45);
    for (int i = 0; i < 45; i++) begin
      want = window(i, 2, 8'h73) | window(i, 11, 8'h65) | window(i, 20, 8'h70)
           | window(i, 29, 8'h64) | window(i, 38, 8'h62);
      n_cmp++; if (tr_cmd[i] !== want) begin n_bad++; $display("FAIL full_cmd[%0d] got %h want %h", i, tr_cmd[i], want); end
    end
    for (int i = 4; i < 13; i++) begin
      n_cmp++; if (tr_full[i] !== (i >= 5 && i <= 10)) begin
        n_bad++; $display("FAIL full_flag[%0d] got %b", i, tr_full[i]);
      end
    end
    n_cmp++; if (drop_count !== 8'h02) begin n_bad++; $display("FAIL full_drop got %h want 02", drop_count); end
    clear_script();
    for (int i = 0; i < 300; i++) begin s_uv[i] = 1'b1; s_ud[i] = 8'h41; end
    run_script(302);
    n_cmp++; if (drop_count !== 8'hFF) begin n_bad++; $display("FAIL sat_drop got %h want ff", drop_count); end
  endtask

  task automatic test_reset_mid_hold();
    apply_reset();
    for (int i = 0; i < 13; i++) s_btn[i] = 6'b110000;
    s_uv[0] = 1'b1; s_ud[0] = 8'h65;
    s_uv[1] = 1'b1; s_ud[1] = 8'h70;
    s_uv[2] = 1'b1; s_ud[2] = 8'h64;
    s_uv[3] = 1'b1; s_ud[3] = 8'h62;
    s_uv[4] = 1'b1; s_ud[4] = 8'h77;
    run_script(13);
    n_cmp++; if (tr_cmd[12] !== 8'h73) begin n_bad++; $display("FAIL pre_rst_cmd got %h want 73", tr_cmd[12]); end
    n_cmp++; if (tr_full[12] !== 1'b1) begin n_bad++; $display("FAIL pre_rst_full got %b want 1", tr_full[12]); end
    btn = 6'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (cmd_out !== 8'h00) begin n_bad++; $display("FAIL rst_cmd got %h want 00", cmd_out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %b want 0", fifo_full); end
    step(); step();
    reset_n = 1'b1;
    clear_script();
    run_script(30);
    for (int i = 0; i < 30; i++) begin
      n_cmp++; if (tr_cmd[i] !== 8'h00 || tr_busy[i] !== 1'b0) begin
        n_bad++; $display("FAIL post_rst[%0d] cmd %h busy %b want 00/0", i, tr_cmd[i], tr_busy[i]);
      end
    end
  endtask

  task automatic test_random();
    int         shown = 0;
    logic [7:0] want_cmd;
    logic       want_busy;
    logic       want_full;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1000 || c == 2000) apply_reset();
      uart_valid = ($urandom_range(0, 4) == 0);
      uart_data  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : codes[$urandom_range(0, 5)];
      for (int b = 0; b < 6; b++) if ($urandom_range(0, 15) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 63) == 0) is_sleeping = ~is_sleeping;
      step();
      want_cmd  = (m_age < HOLD) ? m_code : 8'h00;
      want_busy = (m_age < HOLD + GAP);
      want_full = (m_q.size() == DEPTH);
      n_cmp++;
      if (cmd_out !== want_cmd || busy !== want_busy || fifo_full !== want_full || drop_count !== 8'(m_drop)) begin
        n_bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random[%0d] got cmd %h busy %b full %b drop %h want %h %b %b %h",
                   c, cmd_out, busy, fifo_full, drop_count, want_cmd, want_busy, want_full, 8'(m_drop));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_uart_single();
    test_back_to_back();
    test_arbitration();
    test_sleep_filter();
    test_fifo_full();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
